sdo_tx: RTL and testbench
=========================

# sdo_tx

Serial output transmitter for the Ascon SPI datapath: accepts 32-bit result words from the core side through a small FIFO and shifts them out MSB-first on `sdo`, framed by `valid`. It is the transmit counterpart of the serial-in/parallel-out receiver that captures `sdo` while `valid` is high. `valid` stays high for a whole message (tag, ciphertext or digest) and drops for at least `GAP_CYCLES` between messages.

## Interface
- `WORD_W`, 32: bits per word.
- `FIFO_DEPTH`, 4: word FIFO depth, power of two, ≥2.
- `GAP_CYCLES`, 2: minimum `valid`-low cycles after a message ends, ≥1.

- `clk`  in  1  interface clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  WORD_W  word to transmit.
- `wr_last`  in  1  marks the final word of a message.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  FIFO not full; a write occurs when `wr_valid && wr_ready`.
- `valid`  out  1  frame strobe, high while message bits are on `sdo`.
- `sdo`  out  1  serial data, MSB first.
- `busy`  out  1  high when not in IDLE or FIFO non-empty.
- `underrun`  out  1  sticky; set when a non-last word finishes with the FIFO empty.

## Operation
- FIFO stores `{wr_last, wr_data}`; read/write pointers wrap modulo `FIFO_DEPTH`; occupancy counter `0..FIFO_DEPTH`.
- Write while full is ignored (`wr_ready` low); simultaneous push and pop leave occupancy unchanged, legal when full or empty-plus-push is not a pop.
- States:
  - IDLE: `valid`=0, `sdo`=0. FIFO non-empty → pop, load shifter, bit counter=WORD_W-1, → SHIFT.
  - SHIFT: `valid`=1, `sdo`=shifter MSB; shift left each cycle, decrement counter. At counter=0:
    - current word not last, FIFO non-empty → pop and reload same cycle, stay in SHIFT (no bubble).
    - current word last → GAP.
    - current word not last, FIFO empty → set `underrun`, → GAP (message truncated).
  - GAP: `valid`=0, `sdo`=0 for `GAP_CYCLES` cycles, then → IDLE.
- `underrun` clears only on `rst`.
- `sdo` and `valid` are registered outputs; no combinational path from inputs.

## Timing
- Reset values: `valid`=0, `sdo`=0, `wr_ready`=1, `busy`=0, `underrun`=0, state IDLE, FIFO empty, pointers 0.
- Latency: word accepted on edge N into empty FIFO while IDLE → popped on edge N+1; `valid`=1 and `sdo`=bit 31 after edge N+1; bit 0 after edge N+32.
- Back-to-back words inside a message: bit 0 of word k is followed on the next edge by bit 31 of word k+1; `valid` never drops.
- `wr_ready` reflects occupancy after the current edge; a pop on the same edge as a write to a full FIFO does not make that write succeed (ready was low).
- Reset mid-frame: `valid`, `sdo` go 0 immediately (async); FIFO contents discarded.
- Per word: exactly WORD_W cycles of `valid`; per message: `valid` high for (words × WORD_W) consecutive cycles.

## Structure
- Package `sdo_tx_pkg`: state enum `tx_state_t` {IDLE, SHIFT, GAP}, default `WORD_W`, `FIFO_DEPTH`, `GAP_CYCLES` constants.
- Sub-module `word_fifo` (synchronous FIFO, width `WORD_W+1`, depth `FIFO_DEPTH`, full/empty/count, async active-high reset); top holds FSM, shifter, bit and gap counters.

## Test plan
- Single word 0xA5A5_0F0F with `wr_last`=1 → `valid` high 32 cycles, `sdo` sequence 1,0,1,0,0,1,0,1,…,1,1,1,1; receiver captures 0xA5A5_0F0F; `valid` low ≥2 cycles after.
- Four words 0x0000_0001, 0x8000_0000, 0xFFFF_FFFF, 0x1234_5678 (last on 4th) written back-to-back → `valid` high exactly 128 consecutive cycles, receiver outputs the four words in order, `underrun`=0.
- Six writes with no pop stall (message of 6 words) → `wr_ready` low once 4 stored; writes held until ready; all 6 words transmitted in order with no gap.
- Two words, first not last, second written 40 cycles later → `underrun`=1 after 32 `valid` cycles, `valid` drops; second word then sent as new frame.
- Assert `rst` at bit 10 of a word → `valid`, `sdo` 0 immediately, `wr_ready`=1, `busy`=0; next written word transmits from bit 31 cleanly.
- Two one-word messages queued together → `valid` low for exactly `GAP_CYCLES`=2 between the two 32-cycle frames.

Source files
------------

// File: rtl/sdo_tx_pkg.sv
// sdo_tx_pkg: shared state encoding and default sizing for the serial output transmitter
package sdo_tx_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;
   localparam int DEF_WORD_W     = 32;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_GAP_CYCLES = 2;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous FIFO with occupancy count; pushes when full and pops when empty are dropped
module word_fifo #(
   parameter int W = 33,
   parameter int D = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(D+1)-1:0]   count
);
   localparam int AW = $clog2(D);
   localparam int CW = $clog2(D+1);
   logic [W-1:0]  mem [D];
   logic [AW-1:0] wptr, rptr;
   logic          push, pop;
   assign full    = count == CW'(D);
   assign empty   = count == '0;
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rptr];
   always_ff @(posedge clk)
      if (push) mem[wptr] <= wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= push ? wptr + 1'b1 : wptr;
         rptr  <= pop ? rptr + 1'b1 : rptr;
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/sdo_tx.sv
// sdo_tx: FIFO-fed MSB-first serialiser framing each message with valid and a minimum idle gap
module sdo_tx import sdo_tx_pkg::*; #(
   parameter int WORD_W     = DEF_WORD_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              valid,
   output logic              sdo,
   output logic              busy,
   output logic              underrun
);
   localparam int CW = $clog2(WORD_W);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   tx_state_t                       state;
   logic [WORD_W-1:0]               shreg;
   logic [CW-1:0]                   bit_cnt;
   logic [GW-1:0]                   gap_cnt;
   logic                            cur_last;
   logic [WORD_W:0]                 rd_data;
   logic                            full, empty, pop, word_end;
   logic [$clog2(FIFO_DEPTH+1)-1:0] count;
   word_fifo #(.W(WORD_W + 1), .D(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_valid),
      .wr_data ({wr_last, wr_data}),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );
   assign wr_ready = !full;
   assign busy     = state != IDLE || count != '0;
   assign word_end = bit_cnt == '0;
   // the final gap cycle hands straight to the next word so the gap is exactly GAP_CYCLES long
   assign pop = !empty && (state == IDLE || (state == SHIFT && word_end && !cur_last) ||
                           (state == GAP && gap_cnt == '0));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         valid    <= 1'b0;
         sdo      <= 1'b0;
         underrun <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         cur_last <= 1'b0;
      end else if (pop) begin
         state    <= SHIFT;
         valid    <= 1'b1;
         sdo      <= rd_data[WORD_W-1];
         shreg    <= {rd_data[WORD_W-2:0], 1'b0};
         cur_last <= rd_data[WORD_W];
         bit_cnt  <= CW'(WORD_W - 1);
      end else begin
         case (state)
            SHIFT:
               if (!word_end) begin
                  sdo     <= shreg[WORD_W-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt - 1'b1;
               end else begin
                  state    <= GAP;
                  valid    <= 1'b0;
                  sdo      <= 1'b0;
                  gap_cnt  <= GW'(GAP_CYCLES - 1);
                  underrun <= underrun | !cur_last;
               end
            GAP:
               if (gap_cnt == '0) state <= IDLE;
               else gap_cnt <= gap_cnt - 1'b1;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_sdo_tx.sv
// tb_sdo_tx: directed checks of sdo_tx framing, latency, back-pressure, underrun, reset and gap length
module tb_sdo_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wr_data = '0;
   logic        wr_last = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready, valid, sdo, busy, underrun;
   int          total = 0;
   int          bad = 0;
   logic [31:0] rx_q[$];
   int          runs_q[$];
   int          gaps_q[$];
   logic [31:0] rsh = '0;
   int          rbits = 0;
   int          hi = 0;
   int          lo = 0;
   bit          seen = 1'b0;

   always #5 clk = ~clk;

   sdo_tx dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_last  (wr_last),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .valid    (valid),
      .sdo      (sdo),
      .busy     (busy),
      .underrun (underrun)
   );

   // receiver model: captures sdo while valid, records frame lengths and inter-frame gaps
   always @(posedge rst) begin
      rbits = 0;
      hi = 0;
      lo = 0;
      seen = 1'b0;
   end
   always @(negedge clk)
      if (!rst) begin
         if (valid) begin
            if (hi == 0 && seen) gaps_q.push_back(lo);
            rsh = {rsh[30:0], sdo};
            rbits++;
            if (rbits == 32) begin
               rx_q.push_back(rsh);
               rbits = 0;
            end
            hi++;
            lo = 0;
         end else begin
            if (hi != 0) begin
               runs_q.push_back(hi);
               seen = 1'b1;
               rbits = 0;
            end
            hi = 0;
            lo++;
         end
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic l);
      int t = 0;
      wr_data = d;
      wr_last = l;
      wr_valid = 1'b1;
      while (!wr_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("push_timeout", 32'(t < 500), 1);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", 32'(t < 2000), 1);
      @(negedge clk);
   endtask

   task automatic chk_word(input string tag, input logic [31:0] exp);
      chk(tag, rx_q.size() > 0 ? rx_q.pop_front() : 32'hxxxx_xxxx, exp);
   endtask

   task automatic chk_run(input string tag, input int exp);
      chk(tag, runs_q.size() > 0 ? 32'(runs_q.pop_front()) : 32'hxxxx_xxxx, 32'(exp));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", 32'(valid), 0);
      chk("rst_sdo", 32'(sdo), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_underrun", 32'(underrun), 0);
      @(negedge clk);

      push(32'hA5A5_0F0F, 1'b1);
      wr_valid = 1'b0;
      chk("lat_valid_before_pop", 32'(valid), 0);
      chk("lat_busy", 32'(busy), 1);
      @(negedge clk);
      chk("lat_valid_first", 32'(valid), 1);
      chk("lat_sdo_bit31", 32'(sdo), 1);
      @(negedge clk);
      chk("lat_sdo_bit30", 32'(sdo), 0);
      repeat (30) @(negedge clk);
      chk("lat_valid_bit0", 32'(valid), 1);
      chk("lat_sdo_bit0", 32'(sdo), 1);
      @(negedge clk);
      chk("lat_valid_end", 32'(valid), 0);
      chk("lat_sdo_end", 32'(sdo), 0);
      wait_idle();
      chk("t1_nwords", 32'(rx_q.size()), 1);
      chk_word("t1_word", 32'hA5A5_0F0F);
      chk_run("t1_run", 32);
      chk("t1_underrun", 32'(underrun), 0);

      push(32'h0000_0001, 1'b0);
      push(32'h8000_0000, 1'b0);
      push(32'hFFFF_FFFF, 1'b0);
      push(32'h1234_5678, 1'b1);
      wr_valid = 1'b0;
      wait_idle();
      chk("t2_nwords", 32'(rx_q.size()), 4);
      chk_word("t2_w0", 32'h0000_0001);
      chk_word("t2_w1", 32'h8000_0000);
      chk_word("t2_w2", 32'hFFFF_FFFF);
      chk_word("t2_w3", 32'h1234_5678);
      chk_run("t2_run", 128);
      chk("t2_underrun", 32'(underrun), 0);

      push(32'h1111_1111, 1'b0);
      push(32'h2222_2222, 1'b0);
      push(32'h3333_3333, 1'b0);
      push(32'h4444_4444, 1'b0);
      push(32'h5555_5555, 1'b0);
      chk("t3_full_ready", 32'(wr_ready), 0);
      push(32'h6666_6666, 1'b1);
      wr_valid = 1'b0;
      wait_idle();
      chk("t3_nwords", 32'(rx_q.size()), 6);
      chk_word("t3_w0", 32'h1111_1111);
      chk_word("t3_w1", 32'h2222_2222);
      chk_word("t3_w2", 32'h3333_3333);
      chk_word("t3_w3", 32'h4444_4444);
      chk_word("t3_w4", 32'h5555_5555);
      chk_word("t3_w5", 32'h6666_6666);
      chk_run("t3_run", 192);
      chk("t3_underrun", 32'(underrun), 0);

      push(32'hCAFE_0001, 1'b0);
      wr_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("t4_underrun", 32'(underrun), 1);
      chk("t4_valid_dropped", 32'(valid), 0);
      chk_word("t4_w0", 32'hCAFE_0001);
      chk_run("t4_run_trunc", 32);
      push(32'hCAFE_0002, 1'b1);
      wr_valid = 1'b0;
      wait_idle();
      chk_word("t4_w1", 32'hCAFE_0002);
      chk_run("t4_run_new", 32);
      chk("t4_underrun_sticky", 32'(underrun), 1);

      push(32'hDEAD_BEEF, 1'b1);
      wr_valid = 1'b0;
      repeat (22) @(negedge clk);
      chk("t5_valid_bit10", 32'(valid), 1);
      chk("t5_sdo_bit10", 32'(sdo), 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(valid), 0);
      chk("t5_rst_sdo", 32'(sdo), 0);
      chk("t5_rst_wr_ready", 32'(wr_ready), 1);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_underrun", 32'(underrun), 0);
      @(negedge clk);
      rst = 1'b0;
      runs_q.delete();
      @(negedge clk);
      push(32'h0F1E_2D3C, 1'b1);
      wr_valid = 1'b0;
      wait_idle();
      chk("t5_nwords", 32'(rx_q.size()), 1);
      chk_word("t5_word", 32'h0F1E_2D3C);
      chk_run("t5_run", 32);

      push(32'h5A5A_5A5A, 1'b1);
      push(32'h3C3C_C3C3, 1'b1);
      wr_valid = 1'b0;
      wait_idle();
      chk_word("t6_w0", 32'h5A5A_5A5A);
      chk_word("t6_w1", 32'h3C3C_C3C3);
      chk_run("t6_run0", 32);
      chk_run("t6_run1", 32);
      chk("t6_gap", gaps_q.size() > 0 ? 32'(gaps_q[$]) : 32'hxxxx_xxxx, 2);
      chk("t6_underrun", 32'(underrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
